// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the arbitrated ALU.
// Imported by alu_core and alu_arbiter.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational logic/arithmetic unit shared between requesters.
// Carry is only meaningful for ADD and is forced low otherwise.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y    = '0;
        cout = 1'b0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_ADD: {cout, y} = w_sum;
            default: begin
                y    = '0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sequencing two requesters through one alu_core.
// One operation in flight: IDLE grants, EXEC computes, RESP holds result.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_cout
);

    state_t           r_state;
    logic             r_last_grant;
    logic             r_id;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_idle;
    logic [WIDTH-1:0] w_y;
    logic             w_cout;

    // On a tie the requester that did not win last time goes next.
    assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_idle   = (r_state == IDLE) & ~rst;

    assign req0_ready = w_idle & w_grant0;
    assign req1_ready = w_idle & w_grant1;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op   (r_op),
        .a    (r_a),
        .b    (r_b),
        .y    (w_y),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_y        <= '0;
            rsp_cout     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 | w_grant1) begin
                        r_id         <= w_grant1;
                        r_op         <= w_grant1 ? req1_op : req0_op;
                        r_a          <= w_grant1 ? req1_a : req0_a;
                        r_b          <= w_grant1 ? req1_b : req0_b;
                        r_last_grant <= w_grant1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y     <= w_y;
                    rsp_cout  <= w_cout;
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios, exhaustive sweep and a
// randomized transaction-level scoreboard with round-robin model.
module tb_alu_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready;
    logic [1:0]   req0_op;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [1:0]   req1_op;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [W-1:0] rsp_y;

    int n_pass  = 0;
    int n_total = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_cout   (rsp_cout)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_alu(logic [1:0] op,
                                           logic [3:0] a,
                                           logic [3:0] b);
        int s;
        case (op)
            2'd0: return {1'b0, a & b};
            2'd1: return {1'b0, a | b};
            2'd2: return {1'b0, a ^ b};
            default: begin
                s = int'(a) + int'(b);
                return 5'(s);
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_grant(output int who);
        who = -1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (req0_ready) begin
                who = 0;
                return;
            end
            if (req1_ready) begin
                who = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (rsp_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b0;
        tick();
        tick();
        #1;
        n_total++;
        if ({req0_ready, req1_ready} !== 2'b00)
            $display("FAIL rst_ready got %b want 00", {req0_ready, req1_ready});
        else n_pass++;
        n_total++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_y} !== 7'd0)
            $display("FAIL rst_outputs got v%b id%b c%b y%h want all 0",
                     rsp_valid, rsp_id, rsp_cout, rsp_y);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL rst_first_tie got %b want 10", {req0_ready, req1_ready});
        else n_pass++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_or();
        rsp_ready = 1'b1;
        req0_op = 2'b01;
        req0_a = 4'b1010;
        req0_b = 4'b0110;
        req0_valid = 1'b1;
        #1;
        n_total++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL or_accept got %b want 10", {req0_ready, req1_ready});
        else n_pass++;
        tick();
        req0_valid = 1'b0;
        req0_a = 4'b0000;
        req0_b = 4'b0000;
        #1;
        n_total++;
        if (rsp_valid !== 1'b0 || req0_ready !== 1'b0)
            $display("FAIL or_exec got v%b r%b want v0 r0", rsp_valid, req0_ready);
        else n_pass++;
        tick();
        #1;
        n_total++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_y} !== {3'b100, 4'b1110})
            $display("FAIL or_rsp got v%b id%b c%b y%b want v1 id0 c0 y1110",
                     rsp_valid, rsp_id, rsp_cout, rsp_y);
        else n_pass++;
        tick();
        #1;
        n_total++;
        if (rsp_valid !== 1'b0)
            $display("FAIL or_done got v%b want 0", rsp_valid);
        else n_pass++;
    endtask

    task automatic test_add_overflow();
        int who;
        rsp_ready = 1'b1;
        req1_op = 2'b11;
        req1_a = 4'b1111;
        req1_b = 4'b0001;
        req1_valid = 1'b1;
        wait_grant(who);
        n_total++;
        if (who !== 1) $display("FAIL add_grant got %0d want 1", who);
        else n_pass++;
        tick();
        req1_valid = 1'b0;
        req1_a = 4'($urandom);
        tick();
        #1;
        n_total++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_y} !== {3'b111, 4'b0000})
            $display("FAIL add_rsp got v%b id%b c%b y%b want v1 id1 c1 y0000",
                     rsp_valid, rsp_id, rsp_cout, rsp_y);
        else n_pass++;
        tick();
    endtask

    task automatic test_fairness();
        int left0 = 4;
        int left1 = 4;
        int who;
        int expd;
        bit last = 1'b1;
        bit ok;
        logic [3:0] ey;
        rsp_ready = 1'b1;
        req0_op = 2'b00;
        req0_a = 4'b1100;
        req0_b = 4'b1010;
        req1_op = 2'b10;
        req1_a = 4'b1100;
        req1_b = 4'b1010;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (left0 > 0 && left1 > 0) expd = last ? 0 : 1;
            else expd = (left0 > 0) ? 0 : 1;
            ey = (expd == 0) ? 4'b1000 : 4'b0110;
            wait_grant(who);
            n_total++;
            if (who !== expd)
                $display("FAIL fair_grant%0d got %0d want %0d", i, who, expd);
            else n_pass++;
            tick();
            last = expd[0];
            if (expd == 0) left0--;
            else left1--;
            if (left0 == 0) req0_valid = 1'b0;
            if (left1 == 0) req1_valid = 1'b0;
            wait_rsp(ok);
            n_total++;
            if (!ok || rsp_id !== expd[0] || rsp_y !== ey)
                $display("FAIL fair_rsp%0d got ok%0d id%b y%b want id%0d y%b",
                         i, ok, rsp_id, rsp_y, expd, ey);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        int who;
        bit ok;
        bit held = 1'b1;
        rsp_ready = 1'b0;
        req0_op = 2'b11;
        req0_a = 4'd3;
        req0_b = 4'd4;
        req0_valid = 1'b1;
        wait_grant(who);
        tick();
        req0_valid = 1'b0;
        req1_op = 2'b01;
        req1_a = 4'd5;
        req1_b = 4'd8;
        req1_valid = 1'b1;
        wait_rsp(ok);
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            if (!rsp_valid || rsp_y !== 4'd7 || rsp_id !== 1'b0 ||
                req0_ready || req1_ready)
                held = 1'b0;
        end
        n_total++;
        if (!ok || !held)
            $display("FAIL bp_hold got ok%0d held%0d y%h r1%b want ok1 held1 y7",
                     ok, held, rsp_y, req1_ready);
        else n_pass++;
        rsp_ready = 1'b1;
        tick();
        #1;
        n_total++;
        if ({rsp_valid, req1_ready} !== 2'b01)
            $display("FAIL bp_release got v%b r1%b want v0 r1",
                     rsp_valid, req1_ready);
        else n_pass++;
        tick();
        req1_valid = 1'b0;
        wait_rsp(ok);
        n_total++;
        if (!ok || rsp_id !== 1'b1 || rsp_y !== 4'd13)
            $display("FAIL bp_req1 got ok%0d id%b y%h want id1 yd", ok, rsp_id, rsp_y);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int who;
        bit quiet = 1'b1;
        bit ok;
        rsp_ready = 1'b1;
        req1_op = 2'b00;
        req1_a = 4'hF;
        req1_b = 4'hF;
        req1_valid = 1'b1;
        wait_grant(who);
        tick();
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();
        #1;
        n_total++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_y} !== 7'd0)
            $display("FAIL rmid_clear got v%b id%b c%b y%h want all 0",
                     rsp_valid, rsp_id, rsp_cout, rsp_y);
        else n_pass++;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            if (rsp_valid) quiet = 1'b0;
        end
        n_total++;
        if (!quiet) $display("FAIL rmid_dropped got a response want none");
        else n_pass++;
        req0_op = 2'b10;
        req0_a = 4'h9;
        req0_b = 4'h3;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_total++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL rmid_tie got %b want 10", {req0_ready, req1_ready});
        else n_pass++;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(ok);
        n_total++;
        if (!ok || rsp_id !== 1'b0 || rsp_y !== 4'hA)
            $display("FAIL rmid_rsp got ok%0d id%b y%h want id0 ya", ok, rsp_id, rsp_y);
        else n_pass++;
        tick();
    endtask

    task automatic test_sweep();
        int who;
        bit ok;
        logic [4:0] e;
        rsp_ready = 1'b1;
        for (int o = 0; o < 4; o++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    req0_op = 2'(o);
                    req0_a = 4'(a);
                    req0_b = 4'(b);
                    req0_valid = 1'b1;
                    e = ref_alu(2'(o), 4'(a), 4'(b));
                    wait_grant(who);
                    tick();
                    req0_valid = 1'b0;
                    wait_rsp(ok);
                    n_total++;
                    if (who !== 0 || !ok || {rsp_cout, rsp_y} !== e)
                        $display("FAIL sweep op%0d a%0d b%0d got g%0d ok%0d c%b y%h want c%b y%h",
                                 o, a, b, who, ok, rsp_cout, rsp_y, e[4], e[3:0]);
                    else n_pass++;
                    tick();
                end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] op[2];
        logic [3:0] a[2];
        logic [3:0] b[2];
        bit pend[2];
        bit last;
        bit ok;
        int who;
        int expd;
        logic [4:0] e;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
        last = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) != 0) begin
                    pend[r] = 1'b1;
                    op[r] = 2'($urandom);
                    a[r] = 4'($urandom);
                    b[r] = 4'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1'b1;
                op[0] = 2'($urandom);
                a[0] = 4'($urandom);
                b[0] = 4'($urandom);
            end
            req0_valid = pend[0];
            req0_op = op[0];
            req0_a = a[0];
            req0_b = b[0];
            req1_valid = pend[1];
            req1_op = op[1];
            req1_a = a[1];
            req1_b = b[1];
            if (pend[0] && pend[1]) expd = last ? 0 : 1;
            else expd = pend[0] ? 0 : 1;
            rsp_ready = 1'b0;
            wait_grant(who);
            n_total++;
            if (who !== expd) begin
                $display("FAIL rnd_grant%0d got %0d want %0d", t, who, expd);
                break;
            end else n_pass++;
            tick();
            pend[expd] = 1'b0;
            last = expd[0];
            e = ref_alu(op[expd], a[expd], b[expd]);
            if (expd == 0) begin
                req0_valid = 1'b0;
                req0_a = 4'($urandom);
            end else begin
                req1_valid = 1'b0;
                req1_b = 4'($urandom);
            end
            wait_rsp(ok);
            repeat ($urandom_range(0, 3)) tick();
            #1;
            n_total++;
            if (!ok || rsp_id !== expd[0] || {rsp_cout, rsp_y} !== e)
                $display("FAIL rnd_rsp%0d got ok%0d id%b c%b y%h want id%0d c%b y%h",
                         t, ok, rsp_id, rsp_cout, rsp_y, expd, e[4], e[3:0]);
            else n_pass++;
            rsp_ready = 1'b1;
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0;
        req0_op = '0;
        req0_a = '0;
        req0_b = '0;
        req1_valid = 1'b0;
        req1_op = '0;
        req1_a = '0;
        req1_b = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_or();
        test_add_overflow();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
